// File: rtl/t08_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : t08_mdu_pkg
// Purpose  : Shared types and helpers for the t08 multiply/divide unit.
//            Provides the RV32M funct3 operation encoding, the control FSM
//            state type and small operation-classification functions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package t08_mdu_pkg;

  // RV32M funct3 encoding; every 3-bit code is a defined operation.
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  // Divide and remainder operations all have funct3[2] set.
  function automatic logic op_is_div(input mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input mdu_op_t op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_b_signed(input mdu_op_t op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/t08_mdu_core.sv
`default_nettype none
// ============================================================================
// Module   : t08_mdu_core
// Purpose  : One iteration of the unsigned datapath. Multiply is a radix-2
//            shift-add on a {hi,lo} product register (lo holds the remaining
//            multiplier bits); divide is a restoring shift-subtract step
//            (hi holds the partial remainder, lo shifts the dividend out and
//            the quotient in).
// Ports    : i_is_div  - 1 selects divide step, 0 selects multiply step
//            i_hi      - upper accumulator (product high / remainder)
//            i_lo      - lower accumulator (multiplier / dividend-quotient)
//            i_m       - multiplicand magnitude / divisor magnitude
//            o_hi,o_lo - accumulators after this iteration
// Revision : 1.0 - initial release
// ============================================================================
module t08_mdu_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  always_comb begin
    // Multiply: conditionally add, then shift the whole {carry,hi,lo} right.
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : {(WIDTH+1){1'b0}});
    // Divide: bring the next dividend bit into the partial remainder.
    w_shift = {i_hi, i_lo[WIDTH-1]};
    // The remainder is always below the divisor, so the shifted value fits
    // in WIDTH+1 bits and the top bit of the difference is a clean borrow.
    w_diff  = w_shift - {1'b0, i_m};
    if (i_is_div) begin
      if (!w_diff[WIDTH]) begin
        o_hi = w_diff[WIDTH-1:0];
        o_lo = {i_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_hi = w_shift[WIDTH-1:0];
        o_lo = {i_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/t08_mdu.sv
`default_nettype none
// ============================================================================
// Module   : t08_mdu
// Purpose  : Iterative RV32M multiply/divide unit, one bit per cycle.
//            Operands are converted to magnitudes on acceptance, iterated in
//            t08_mdu_core, then sign-corrected and selected in FIX.
//            Divide-by-zero and signed overflow skip the iterations.
// Ports    : clk        - clock, rising edge
//            nRst       - asynchronous active-low reset
//            start      - launch request, sampled only in IDLE
//            flush      - aborts an in-flight operation
//            op         - RV32M funct3 (mdu_op_t)
//            operand_a  - rs1 (multiplicand / dividend)
//            operand_b  - rs2 (multiplier / divisor)
//            result     - registered result, held until the next result
//            busy       - operation in progress
//            done       - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module t08_mdu
  import t08_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_t         r_state, w_next;
  mdu_op_t            r_op;
  logic               r_neg_a, r_neg_b, r_special;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_m, r_result;

  mdu_op_t            w_op;
  logic               w_is_div, w_a_neg, w_b_neg, w_b_zero, w_ovf, w_special;
  logic               w_accept;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_core_hi, w_core_lo;
  logic [WIDTH-1:0]   w_quot, w_rem, w_fix;
  logic [2*WIDTH-1:0] w_prod;

  // ---------------- launch decode ----------------
  assign w_op     = mdu_op_t'(op);
  assign w_is_div = op_is_div(w_op);
  assign w_a_neg  = op_a_signed(w_op) & operand_a[WIDTH-1];
  assign w_b_neg  = op_b_signed(w_op) & operand_b[WIDTH-1];
  // Negating the most-negative value yields itself, which is its correct
  // unsigned magnitude.
  assign w_a_mag  = w_a_neg ? -operand_a : operand_a;
  assign w_b_mag  = w_b_neg ? -operand_b : operand_b;
  assign w_b_zero = (operand_b == '0);
  assign w_ovf    = ((w_op == DIV) || (w_op == REM)) &&
                    (operand_a == C_MOST_NEG) && (operand_b == '1);
  assign w_special = w_is_div && (w_b_zero || w_ovf);
  assign w_accept  = (r_state == IDLE) && start && !flush;

  t08_mdu_core #(.WIDTH(WIDTH)) u_core (
    .i_is_div (op_is_div(r_op)),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_m      (r_m),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start && !flush) w_next = w_special ? FIX : CALC;
      CALC:    if (flush) w_next = IDLE;
               else if (r_cnt == CNT_W'(1)) w_next = FIX;
      FIX:     w_next = flush ? IDLE : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_op      <= MUL;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_special <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_m       <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_neg_a   <= w_a_neg;
      r_neg_b   <= w_b_neg;
      r_special <= w_special;
      r_cnt     <= CNT_W'(WIDTH);
      // Special cases preload the final quotient (lo) and remainder (hi).
      if (w_is_div && w_b_zero) begin
        r_hi <= operand_a;
        r_lo <= '1;
      end else if (w_special) begin
        r_hi <= '0;
        r_lo <= operand_a;
      end else if (w_is_div) begin
        r_hi <= '0;
        r_lo <= w_a_mag;
        r_m  <= w_b_mag;
      end else begin
        r_hi <= '0;
        r_lo <= w_b_mag;
        r_m  <= w_a_mag;
      end
    end else if ((r_state == CALC) && !flush) begin
      r_hi  <= w_core_hi;
      r_lo  <= w_core_lo;
      r_cnt <= r_cnt - CNT_W'(1);
    end else if ((r_state == FIX) && !flush) begin
      r_result <= w_fix;
    end
  end

  // ---------------- sign fix-up and result select ----------------
  always_comb begin
    w_prod = {r_hi, r_lo};
    if (r_neg_a ^ r_neg_b) w_prod = -w_prod;
    w_quot = r_lo;
    w_rem  = r_hi;
    if (!r_special) begin
      if (r_neg_a ^ r_neg_b) w_quot = -r_lo;
      if (r_neg_a)           w_rem  = -r_hi;
    end
    case (r_op)
      MUL:                 w_fix = w_prod[WIDTH-1:0];
      MULH, MULHSU, MULHU: w_fix = w_prod[2*WIDTH-1:WIDTH];
      DIV, DIVU:           w_fix = w_quot;
      default:             w_fix = w_rem;
    endcase
  end

  assign result = r_result;
  assign busy   = (r_state == CALC) || (r_state == FIX);
  assign done   = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_t08_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_t08_mdu
// Purpose  : Self-checking bench for t08_mdu (WIDTH=32). A behavioural model
//            computes results with plain wide arithmetic and tracks busy/done
//            as a countdown of edges; a compare process checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t08_mdu;

  localparam int W = 32;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2,
                         OP_MULHU = 3'd3, OP_DIV = 3'd4, OP_DIVU = 3'd5,
                         OP_REM = 3'd6, OP_REMU = 3'd7;

  logic         clk = 1'b0;
  logic         nRst = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [W-1:0] result;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  t08_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (result),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic is_special(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    return o[2] && ((b == '0) ||
           (((o == OP_DIV) || (o == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] sa, sb, ua, ub, p;
    logic [W-1:0]   r;
    logic           ovf;
    sa  = {{W{a[W-1]}}, a};
    sb  = {{W{b[W-1]}}, b};
    ua  = {{W{1'b0}}, a};
    ub  = {{W{1'b0}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    r   = '0;
    case (o)
      OP_MUL:    begin p = ua * ub; r = p[W-1:0];   end
      OP_MULH:   begin p = sa * sb; r = p[2*W-1:W]; end
      OP_MULHSU: begin p = sa * ub; r = p[2*W-1:W]; end
      OP_MULHU:  begin p = ua * ub; r = p[2*W-1:W]; end
      OP_DIV:    r = (b == '0) ? '1 : ovf ? a : W'($signed(a) / $signed(b));
      OP_DIVU:   r = (b == '0) ? '1 : a / b;
      OP_REM:    r = (b == '0) ? a  : ovf ? '0 : W'($signed(a) % $signed(b));
      default:   r = (b == '0) ? a  : a % b;
    endcase
    return r;
  endfunction

  // ---------------- behavioural timing model ----------------
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_pending = '0;
  int           m_left = 0;   // edges remaining until done rises

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_left   <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (flush) m_busy <= 1'b0;
      else if (m_left == 1) begin
        m_busy   <= 1'b0;
        m_done   <= 1'b1;
        m_result <= m_pending;
      end else m_left <= m_left - 1;
    end else if (start && !flush) begin
      m_busy    <= 1'b1;
      m_pending <= ref_result(op, operand_a, operand_b);
      m_left    <= is_special(op, operand_a, operand_b) ? 1 : W + 1;
    end
  end

  always @(negedge clk) begin
    check("busy",   W'(busy), W'(m_busy));
    check("done",   W'(done), W'(m_done));
    check("result", result,   m_result);
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    int lat;
    int nbusy;
    check({name, " model"}, ref_result(o, a, b), exp);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();                       // accepting edge E0
    start = 1'b0;
    op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    lat = 0;
    nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    check({name, " latency"}, W'(lat), W'(exp_lat));
    check({name, " busy cycles"}, W'(nbusy), W'(exp_lat));
    check({name, " result"}, result, exp);
    tick();                       // leave DONE
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    repeat (3) tick();
    check("reset result", result, '0);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    nRst = 1'b1;
    tick();

    // Normal ops complete WIDTH+1 edges after the accepting edge.
    directed("MUL 100*200",  OP_MUL,    32'd100,         32'd200,         32'h0000_4E20, W + 1);
    directed("MULH -3*5",    OP_MULH,   -32'sd3,         32'd5,           32'hFFFF_FFFF, W + 1);
    directed("MULHU",        OP_MULHU,  32'hFFFF_FFFF,   32'd2,           32'h0000_0001, W + 1);
    directed("MULHSU",       OP_MULHSU, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFF, W + 1);
    directed("DIV -500/200", OP_DIV,    -32'sd500,       32'd200,         32'hFFFF_FFFE, W + 1);
    directed("REM -500/200", OP_REM,    -32'sd500,       32'd200,         32'hFFFF_FF9C, W + 1);
    directed("DIVU",         OP_DIVU,   32'd100000,      32'd7,           32'd14285,     W + 1);
    directed("REMU",         OP_REMU,   32'd100000,      32'd7,           32'd5,         W + 1);
    // Fast-path cases complete one edge after acceptance.
    directed("DIVU by 0",    OP_DIVU,   32'd7,           32'd0,           32'hFFFF_FFFF, 1);
    directed("REMU by 0",    OP_REMU,   32'd7,           32'd0,           32'd7,         1);
    directed("DIV ovf",      OP_DIV,    32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000, 1);
    directed("REM ovf",      OP_REM,    32'h8000_0000,   32'hFFFF_FFFF,   32'd0,         1);

    // Flush mid-divide: result keeps the previous value, no done pulse.
    directed("MUL 6*7",      OP_MUL,    32'd6,           32'd7,           32'd42,        W + 1);
    op = OP_DIV; operand_a = 32'd9; operand_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", W'(busy), '0);
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      tick();
    end
    check("flush done count", W'(ndone), '0);
    check("flush result", result, 32'd42);
    directed("DIVU after flush", OP_DIVU, 32'd100, 32'd7, 32'd14, W + 1);

    // Asynchronous reset in the middle of a divide.
    op = OP_DIV; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    #1 nRst = 1'b0;
    #1;
    check("async rst result", result, '0);
    check("async rst busy", W'(busy), '0);
    check("async rst done", W'(done), '0);
    tick();
    nRst = 1'b1;
    tick();

    // start held through CALC yields a single completion.
    op = OP_MUL; operand_a = 32'd11; operand_b = 32'd13; start = 1'b1;
    ndone = 0;
    repeat (20) begin
      if (done) ndone++;
      tick();
    end
    start = 1'b0;
    repeat (40) begin
      if (done) ndone++;
      tick();
    end
    check("held start done count", W'(ndone), 32'd1);
    check("held start result", result, 32'd143);

    // Randomized traffic, checked every cycle by the model.
    repeat (6000) begin
      start     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 59) == 0);
      op        = 3'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
      case ($urandom_range(0, 7))
        0: operand_b = '0;
        1: begin operand_a = 32'h8000_0000; operand_b = 32'hFFFF_FFFF; end
        2: operand_a = $urandom_range(0, 50);
        3: operand_b = $urandom_range(1, 9);
        4: operand_b = -($urandom_range(1, 9));
        default: ;
      endcase
      tick();
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/t08_mdu.md
Name: t08_mdu

Overview:
- Iterative multiply/divide unit implementing the RV32M operations, parametrised in datapath width.
- Sits beside t08_alu in the execute stage. The control unit launches an operation with a start pulse and stalls the pipeline while busy is high.
- Result is written back when done pulses.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle. Divide-by-zero and signed overflow complete on a fast path.

Parameters:
WIDTH, 32, operand/result width in bits; must be even and >= 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
nRst  in  1  reset, asynchronous, active-low
start  in  1  launch request; sampled only in IDLE
flush  in  1  pipeline flush; aborts any in-flight operation
op  in  3  operation, RV32M funct3 encoding (mdu_op_t)
operand_a  in  WIDTH  rs1 value (multiplicand / dividend)
operand_b  in  WIDTH  rs2 value (multiplier / divisor)
result  out  WIDTH  registered result, held until next accepted start
busy  out  1  high from the edge accepting start until the edge that raises done
done  out  1  one-cycle pulse; result is valid while done is high and afterwards

Behaviour:
- Reset (nRst low, any time, including mid-operation):
  - state=IDLE; result=0; busy=0; done=0.
  - Counter and internal accumulators cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start=1 and flush=0 at an edge (E0): latch op, operand_a, operand_b.
  - Record sign flags per op:
    - MULH and DIV/REM: both operands signed.
    - MULHSU: a signed, b unsigned.
    - Others: unsigned.
  - Convert signed operands to magnitudes. busy=1.
  - Next state is FIX if this is a special case, otherwise CALC with counter=WIDTH.
  - start with flush=1 is ignored.
- Special cases (DIV/DIVU/REM/REMU only):
  - operand_b==0: quotient = all ones; remainder = operand_a.
  - Signed overflow (DIV/REM, a = most-negative, b = all ones): quotient = operand_a; remainder = 0.
- CALC:
  - Each edge performs one iteration and decrements the counter.
  - After WIDTH iterations (edges E1..E_WIDTH) go to FIX.
  - Multiply accumulates a 2*WIDTH product.
  - Divide produces a WIDTH-bit quotient and remainder.
- FIX (one edge):
  - Apply sign correction. Product is negated if exactly one signed-input sign is set.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Select the output:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the selection into result. done=1, busy=0, go to DONE.
- DONE: done=1 for exactly this one cycle, then IDLE. start in DONE is ignored; it is sampled again from IDLE.
- Latency, start edge to done high:
  - Normal ops: done is high in the cycle after edge E_(WIDTH+1), i.e. WIDTH+2 cycles (34 at WIDTH=32).
  - Special cases: done is high after E1, i.e. 2 cycles.
- Operands and op may change after E0 without affecting the in-flight operation.
- flush=1 in CALC or FIX: next edge goes to IDLE with busy=0 and done=0; result is unchanged.
- flush=1 in DONE: done still completes its single cycle.
- Arithmetic is modular at WIDTH bits, with no exceptions.
- Invalid op values cannot occur: all 8 funct3 codes are defined.

Decomposition:
- t08_mdu_pkg holds:
  - typedef enum logic [2:0] mdu_op_t {MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7}
  - typedef enum mdu_state_t {IDLE, CALC, FIX, DONE}
- One sub-module, t08_mdu_core: the per-iteration shift-add / restore-subtract datapath step.
- The FSM, sign handling and result mux stay in t08_mdu.

Test Plan (WIDTH=32):
- MUL a=100, b=200 -> result=0x00004E20; done exactly 34 cycles after the start edge; busy high for the preceding 33 cycles.
- MULH a=-3, b=5 -> 0xFFFFFFFF. MULHU a=0xFFFFFFFF, b=2 -> 0x00000001. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-500, b=200 -> 0xFFFFFFFE. REM with the same operands -> 0xFFFFFF9C. DIVU a=100000, b=7 -> 14285. REMU with the same operands -> 5.
- DIVU a=7, b=0 -> 0xFFFFFFFF; REMU a=7, b=0 -> 7. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. Each of these has done 2 cycles after start.
- Start MUL 6*7 and let it complete (result=42). Start DIV 9/3 and assert flush at cycle 10 -> busy falls next edge, done never pulses, result stays 42. A following start works normally.
- nRst low at cycle 15 of a DIV -> result=0, busy=0, done=0 immediately. start held during CALC is ignored, with no second done.
